truth_table_checker: RTL and testbench

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/truth_table_pkg.sv | 19 +
 rtl/tt_settle_counter.sv | 31 +++
 rtl/truth_table_checker.sv | 136 +++++++++++++
 tb/tb_truth_table_checker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    // Settle counter width; covers SETTLE up to 15.
    localparam int unsigned SETTLE_W = 4;

    // Number of input vectors swept for an n_in-input DUT.
    function automatic int unsigned vec_count(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Counts DUT settle cycles for the current vector; expired flags the last one.
module tt_settle_counter
    import truth_table_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [SETTLE_W-1:0] LAST = SETTLE_W'(SETTLE - 1);

    logic [SETTLE_W-1:0] settle_cnt;

    // Settle count: cleared at vector start, advanced while driving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (clear) begin
            settle_cnt <= '0;
        end else if (enable) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    assign expired = (settle_cnt == LAST);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector of a combinational DUT, compares its output with
// an expected truth table and records error count, first failing vector and
// a pass/fail verdict.
module truth_table_checker
    import truth_table_pkg::*;
#(
    parameter int unsigned              N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0]     EXPECTED = 8'hE8,
    parameter int unsigned              SETTLE   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail
);

    localparam int unsigned          NV       = vec_count(N_IN);
    localparam logic [N_IN-1:0]      VEC_LAST = N_IN'(NV - 1);
    localparam logic [(1<<N_IN)-1:0] EXP_TBL  = EXPECTED;

    tt_state_e        state_q;
    tt_state_e        state_d;
    logic [N_IN-1:0]  vec_d;
    logic [N_IN:0]    err_d;
    logic             fail_valid_d;
    logic [N_IN-1:0]  first_fail_d;
    logic             pass_d;
    logic             busy_d;
    logic             done_d;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             cnt_expired;
    logic             mismatch_c;

    tt_settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    // Expected-table lookup for the vector currently applied.
    assign mismatch_c = (dut_y != EXP_TBL[vec_out]);

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_out;
        err_d        = err_count;
        fail_valid_d = fail_valid;
        first_fail_d = first_fail;
        pass_d       = pass;
        cnt_clear    = 1'b0;
        cnt_enable   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                    cnt_clear    = 1'b1;
                    state_d      = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_enable = 1'b1;
                if (cnt_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                cnt_clear = 1'b1;
                if (mismatch_c) begin
                    err_d = err_count + 1'b1;
                    if (!fail_valid) begin
                        fail_valid_d = 1'b1;
                        first_fail_d = vec_out;
                    end
                end
                if (vec_out == VEC_LAST) begin
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_out + 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_out    <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_out    <= vec_d;
            err_count  <= err_d;
            fail_valid <= fail_valid_d;
            first_fail <= first_fail_d;
            pass       <= pass_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: a 3-input majority configuration and a
// 1-input buffer configuration, checked every cycle against a sweep-timeline
// model plus directed literal expectations.
module tb_truth_table_checker;

    logic       clk;
    logic       rst;
    int         mode;      // 0 majority, 1 stuck-at-0, 2 majority inverted at vector 5

    logic       start3, y3, busy3, done3, pass3, fv3;
    logic [2:0] vec3, ff3;
    logic [3:0] err3;

    logic       start1, y1, busy1, done1, pass1, fv1;
    logic [0:0] vec1, ff1;
    logic [1:0] err1;

    int total = 0;
    int bad   = 0;

    truth_table_checker #(.N_IN(3), .EXPECTED(8'hE8), .SETTLE(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .vec_out(vec3), .dut_y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .first_fail(ff3)
    );

    truth_table_checker #(.N_IN(1), .EXPECTED(2'b10), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .vec_out(vec1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .first_fail(ff1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int popcount3(input int v);
        return ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
    endfunction

    // Device under test: majority gate with optional faults / buffer.
    always_comb begin
        y3 = (popcount3(int'(vec3)) >= 2);
        if (mode == 1) y3 = 1'b0;
        else if (mode == 2 && vec3 == 3'd5) y3 = ~y3;
        y1 = vec1[0];
    end

    // ---------------- behavioural model ----------------
    int nv[2] = '{8, 2};
    int st[2] = '{2, 1};
    bit m_act[2], m_fv[2], m_pass[2];
    int m_t[2], m_vec[2], m_err[2], m_ff[2];

    function automatic bit model_exp(input int c, input int v);
        if (c == 0) return popcount3(v) >= 2;
        return (v & 1) == 1;
    endfunction

    function automatic bit model_y(input int c, input int v);
        bit b;
        if (c == 1) return (v & 1) == 1;
        b = popcount3(v) >= 2;
        if (mode == 1) return 1'b0;
        if (mode == 2 && v == 5) return !b;
        return b;
    endfunction

    function automatic bit start_of(input int c);
        return (c == 0) ? start3 : start1;
    endfunction

    function automatic bit done_of(input int c);
        return (c == 0) ? done3 : done1;
    endfunction

    function automatic bit busy_of(input int c);
        return (c == 0) ? busy3 : busy1;
    endfunction

    // Sweep timeline: m_t counts cycles since the first busy cycle.
    always @(posedge clk or posedge rst) begin
        int per, v;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_act[c] = 0; m_fv[c] = 0; m_pass[c] = 0;
                m_t[c] = 0; m_vec[c] = 0; m_err[c] = 0; m_ff[c] = 0;
            end else if (!m_act[c]) begin
                if (start_of(c)) begin
                    m_act[c] = 1; m_t[c] = 0; m_vec[c] = 0;
                    m_err[c] = 0; m_fv[c] = 0; m_ff[c] = 0; m_pass[c] = 0;
                end
            end else begin
                per = st[c] + 1;
                if (m_t[c] == nv[c] * per) begin
                    m_act[c] = 0;
                end else begin
                    if (m_t[c] % per == per - 1) begin
                        v = m_t[c] / per;
                        if (model_y(c, v) != model_exp(c, v)) begin
                            m_err[c]++;
                            if (!m_fv[c]) begin
                                m_fv[c] = 1;
                                m_ff[c] = v;
                            end
                        end
                        if (v == nv[c] - 1) m_pass[c] = (m_err[c] == 0);
                    end
                    m_t[c]++;
                    m_vec[c] = (m_t[c] / per < nv[c]) ? m_t[c] / per : nv[c] - 1;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_cfg(input int c, input logic b, input logic d, input int v,
                           input int e, input logic fv, input int ff, input logic p);
        check($sformatf("c%0d busy", c), int'(b), int'(m_act[c]));
        check($sformatf("c%0d done", c), int'(d),
              int'(m_act[c] && m_t[c] == nv[c] * (st[c] + 1)));
        check($sformatf("c%0d vec_out", c), v, m_vec[c]);
        check($sformatf("c%0d err_count", c), e, m_err[c]);
        check($sformatf("c%0d fail_valid", c), int'(fv), int'(m_fv[c]));
        check($sformatf("c%0d pass", c), int'(p), int'(m_pass[c]));
        if (m_fv[c]) check($sformatf("c%0d first_fail", c), ff, m_ff[c]);
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        cmp_cfg(0, busy3, done3, int'(vec3), int'(err3), fv3, int'(ff3), pass3);
        cmp_cfg(1, busy1, done1, int'(vec1), int'(err1), fv1, int'(ff1), pass1);
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse(input int c);
        @(negedge clk);
        if (c == 0) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        if (c == 0) start3 = 1'b0; else start1 = 1'b0;
    endtask

    task automatic wait_done(input int c, output int nb);
        bit ok;
        nb = 0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (done_of(c)) begin
                ok = 1;
                break;
            end
            if (busy_of(c)) nb++;
            @(negedge clk);
        end
        check($sformatf("c%0d done_seen", c), int'(ok), 1);
    endtask

    task automatic wait_vec3(input int v);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (int'(vec3) == v && busy3) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("vec3_reached", int'(ok), 1);
    endtask

    initial begin
        int nb;
        start3 = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        rst    = 1'b0;
        #1 rst = 1'b1;

        // reset state
        @(negedge clk);
        check("rst busy", int'(busy3), 0);
        check("rst vec_out", int'(vec3), 0);
        check("rst err_count", int'(err3), 0);
        check("rst pass", int'(pass3), 0);
        check("rst done", int'(done3), 0);
        @(negedge clk);
        rst = 1'b0;

        // good majority DUT
        pulse(0);
        wait_done(0, nb);
        check("maj busy_cycles", nb, 24);
        check("maj err_count", int'(err3), 0);
        check("maj pass", int'(pass3), 1);
        check("maj fail_valid", int'(fv3), 0);

        // stuck-at-0 output
        mode = 1;
        pulse(0);
        wait_done(0, nb);
        check("stuck err_count", int'(err3), 4);
        check("stuck first_fail", int'(ff3), 3);
        check("stuck fail_valid", int'(fv3), 1);
        check("stuck pass", int'(pass3), 0);
        repeat (3) @(negedge clk);
        check("idle hold err_count", int'(err3), 4);
        check("idle hold vec_out", int'(vec3), 7);

        // inverted at vector 5
        mode = 2;
        pulse(0);
        wait_done(0, nb);
        check("inv5 err_count", int'(err3), 1);
        check("inv5 first_fail", int'(ff3), 5);
        check("inv5 pass", int'(pass3), 0);

        // start pulsed while busy, then start held high
        pulse(0);
        wait_vec3(2);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_done(0, nb);
        check("busy_start err_count", int'(err3), 1);
        check("busy_start first_fail", int'(ff3), 5);
        @(negedge clk);
        check("gap1 busy", int'(busy3), 0);
        start3 = 1'b1;
        @(negedge clk);
        wait_done(0, nb);
        check("held sweepA busy_cycles", nb, 24);
        @(negedge clk);
        check("held gap busy", int'(busy3), 0);
        check("held gap err_count", int'(err3), 1);
        @(negedge clk);
        check("held restart busy", int'(busy3), 1);
        check("held restart err_count", int'(err3), 0);
        check("held restart vec_out", int'(vec3), 0);
        start3 = 1'b0;
        wait_done(0, nb);
        check("held sweepB err_count", int'(err3), 1);

        // asynchronous reset mid-sweep
        mode = 1;
        pulse(0);
        wait_vec3(4);
        check("pre_rst err_count", int'(err3), 1);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", int'(busy3), 0);
        check("async rst vec_out", int'(vec3), 0);
        check("async rst err_count", int'(err3), 0);
        check("async rst fail_valid", int'(fv3), 0);
        @(negedge clk);
        rst  = 1'b0;
        mode = 0;
        pulse(0);
        wait_done(0, nb);
        check("post_rst busy_cycles", nb, 24);
        check("post_rst err_count", int'(err3), 0);
        check("post_rst pass", int'(pass3), 1);

        // 1-input buffer configuration
        pulse(1);
        wait_done(1, nb);
        check("buf busy_cycles", nb, 4);
        check("buf pass", int'(pass1), 1);
        check("buf err_count", int'(err1), 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
